// File: rtl/mips_pkg.sv
// Shared MiniMIPS datapath constants and types.
package mips_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned PC_STEP = 4;

    typedef logic [ADDR_W-1:0] pc_t;

    localparam pc_t PC_RESET = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/pc_incrementer.sv
// Combinational PC + step adder; also usable for the link-address path.
module pc_incrementer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned INCREMENT = 4
) (
    input  logic [WIDTH-1:0] pc_i,
    output logic [WIDTH-1:0] pc_plus_c_o
);

    // Carry out is dropped on purpose: the PC wraps modulo 2^WIDTH.
    assign pc_plus_c_o = pc_i + WIDTH'(INCREMENT);

endmodule : pc_incrementer

// File: rtl/next_pc_unit.sv
// Program-counter sequencer: each cycle loads reset vector, branch target or PC+step.
module next_pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned     WIDTH        = ADDR_W,
    parameter int unsigned     INCREMENT    = PC_STEP,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             branch,
    input  logic [WIDTH-1:0] branchAddress,
    output logic [WIDTH-1:0] nextPC
);

    // Power-up value lets the block sequence sanely even without a reset pulse.
    logic [WIDTH-1:0] pc_q = RESET_VECTOR;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus;

    pc_incrementer #(
        .WIDTH     (WIDTH),
        .INCREMENT (INCREMENT)
    ) u_pc_incrementer (
        .pc_i        (pc_q),
        .pc_plus_c_o (pc_plus)
    );

    // Branch target is taken verbatim; no alignment masking.
    always_comb begin
        pc_d = pc_plus;
        if (branch) begin
            pc_d = branchAddress;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign nextPC = pc_q;

endmodule : next_pc_unit

// File: tb/tb_next_pc_unit.sv
// Directed-vector bench for next_pc_unit with hand-computed expected PCs.
module tb_next_pc_unit;

    localparam int unsigned W = 32;

    logic         clock;
    logic         reset;
    logic         branch;
    logic [W-1:0] branchAddress;
    logic [W-1:0] nextPC;

    int unsigned n_cmp;
    int unsigned n_err;

    next_pc_unit #(
        .WIDTH        (32),
        .INCREMENT    (4),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .branch        (branch),
        .branchAddress (branchAddress),
        .nextPC        (nextPC)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply inputs, advance one rising edge, sample 1 time unit later.
    task automatic step(input logic rst, input logic br, input logic [W-1:0] addr);
        reset         = rst;
        branch        = br;
        branchAddress = addr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b0;
        branch        = 1'b0;
        branchAddress = '0;

        #1;
        check_val("powerup", nextPC, 32'h0);

        // Reset then free-run
        step(1'b1, 1'b0, 32'h0);
        check_val("reset", nextPC, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 32'h0);
            check_val("freerun", nextPC, W'(4 * i));
        end

        // Branch mid-stream from PC=8
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_val("pre_branch", nextPC, 32'd8);
        step(1'b0, 1'b1, 32'd24);
        check_val("branch", nextPC, 32'd24);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 32'hDEAD_BEEF);
            check_val("post_branch", nextPC, W'(24 + 4 * i));
        end

        // Reset wins over branch
        step(1'b1, 1'b1, 32'h100);
        check_val("rst_prio", nextPC, 32'h0);
        step(1'b0, 1'b0, 32'h100);
        check_val("rst_release", nextPC, 32'h4);

        // Wrap-around
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        check_val("wrap_load", nextPC, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        check_val("wrap", nextPC, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_val("wrap_next", nextPC, 32'h4);

        // Held branch
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h40);
            check_val("held_branch", nextPC, 32'h40);
        end
        step(1'b0, 1'b0, 32'h40);
        check_val("held_release", nextPC, 32'h44);

        // Branch to the current PC holds it; misaligned target is taken verbatim
        step(1'b0, 1'b1, 32'h44);
        check_val("branch_self", nextPC, 32'h44);
        step(1'b0, 1'b1, 32'h123);
        check_val("branch_unaligned", nextPC, 32'h123);
        step(1'b0, 1'b0, 32'h0);
        check_val("unaligned_inc", nextPC, 32'h127);

        // Reset mid-run
        step(1'b0, 1'b1, 32'h30);
        check_val("mid_load", nextPC, 32'h30);
        step(1'b1, 1'b0, 32'h0);
        check_val("mid_reset", nextPC, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check_val("mid_after", nextPC, 32'h4);

        // Reset pulse between edges is ignored; inputs between edges have no comb path
        reset  = 1'b1;
        branch = 1'b1;
        branchAddress = 32'h200;
        #2;
        check_val("no_comb_path", nextPC, 32'h4);
        reset  = 1'b0;
        branch = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        check_val("glitch_ignored", nextPC, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_next_pc_unit

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Program-counter sequencer for the MiniMIPS single-cycle datapath.
- Holds the current instruction address in a register and updates it once per clock.
- Each clock, the register takes either PC+4 (sequential fetch) or an externally computed branch target.
- Its output drives the instruction-memory address and the PC+4 / branch-target adders upstream.

Parameters:
- WIDTH, 32, address width in bits.
- INCREMENT, 4, sequential step in bytes (one MIPS word).
- RESET_VECTOR, 32'h0000_0000, PC value after reset and at power-up.

Ports:
- clock  input  1  rising-edge clock; the only clock domain.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- branch  input  1  when 1 at a rising edge, the PC loads branchAddress.
- branchAddress  input  WIDTH  byte address of the branch/jump target.
- nextPC  output  WIDTH  registered PC value; this is the address of the instruction fetched in the current cycle.

Behaviour:
- Single WIDTH-bit register PC; nextPC = PC, driven directly from the flop with no combinational path from inputs.
- Update rule, evaluated at each rising edge of clock, in priority order:
  1. reset=1 -> PC <= RESET_VECTOR (overrides branch).
  2. branch=1 -> PC <= branchAddress, used verbatim with no alignment masking.
  3. otherwise -> PC <= PC + INCREMENT, modulo 2^WIDTH.
- Latency: exactly one cycle from input sampling to the visible nextPC change. Inputs may change at any time between edges; only the values at the edge matter.
- Power-up: PC is initialised to RESET_VECTOR so the block sequences correctly even if reset is never asserted.
- Wrap-around: PC = 2^WIDTH - INCREMENT with no branch -> PC becomes 0. No error flag.
- Branch to the current PC value is legal and holds the PC for that cycle.
- Reset asserted mid-run: takes effect at the next edge; asynchronous glitches on reset between edges are ignored.
- Reset released: the first edge with reset=0 applies the branch/increment rule to RESET_VECTOR.
- Branch held high for several cycles: PC reloads branchAddress on every such edge.
- No handshake and no stall input; the PC advances every cycle.

Decomposition:
- Shared package mips_pkg holds:
  - ADDR_W = 32
  - PC_STEP = 4
  - PC_RESET = 32'h0
  - a pc_t typedef of logic [ADDR_W-1:0]
- Optional sub-module pc_incrementer: a combinational adder computing PC + INCREMENT. It is reusable for the link-address (PC+4) path.
- Everything else stays flat in next_pc_unit.

Test Plan:
- Reset then free-run: reset=1 for one edge, then branch=0 for 4 edges -> nextPC = 0, 4, 8, 12, 16.
- Branch mid-stream: from PC=8, branchAddress=24, branch=1 for one edge, then branch=0 -> nextPC = 24, then 28, 32, 36, 40, 44.
- Reset priority: reset=1 and branch=1 with branchAddress=0x100 at the same edge -> nextPC = 0.
- Wrap-around: branch to 0xFFFF_FFFC, then increment -> nextPC = 0xFFFF_FFFC, then 0x0000_0000.
- Held branch: branch=1 for 3 edges with branchAddress=0x40 -> nextPC = 0x40 on all 3 edges; after release, 0x44.
- Reset mid-run: at PC=0x30, reset=1 for one edge -> nextPC = 0; next edge with branch=0 -> 4. A reset pulse that does not span a rising edge has no effect.
